// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl
// Purpose  : Multi-cycle controller for the MIPS-subset datapath, with a
//            retired-instruction counter. Optional macro ILLEGAL_TRAP_EN
//            halts on unknown instructions instead of retiring them as NOPs.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl #(
    parameter int         CNT_W       = 32,
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_wr,
    output logic             mem_wr,
    output logic [1:0]       extop,
    output logic             alu_src,
    output logic [1:0]       aluop,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       npc_sel,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    localparam logic [3:0] c_S_FETCH  = 4'd0;
    localparam logic [3:0] c_S_DECODE = 4'd1;
    localparam logic [3:0] c_S_MA     = 4'd2;
    localparam logic [3:0] c_S_MR     = 4'd3;
    localparam logic [3:0] c_S_MW     = 4'd4;
    localparam logic [3:0] c_S_WBM    = 4'd5;
    localparam logic [3:0] c_S_EXE    = 4'd6;
    localparam logic [3:0] c_S_WBA    = 4'd7;
    localparam logic [3:0] c_S_BR     = 4'd8;
    localparam logic [3:0] c_S_JMP    = 4'd9;
    localparam logic [3:0] c_S_HALT   = 4'd10;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_retire;
    logic       w_pc_wr, w_ir_wr, w_reg_wr, w_mem_wr;

    logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
    logic w_is_mem, w_is_alu, w_is_jmp, w_unknown;

    assign w_rtype   = (op == c_OP_RTYPE);
    assign w_addu    = w_rtype && (funct == c_FN_ADDU);
    assign w_subu    = w_rtype && (funct == c_FN_SUBU);
    assign w_jr      = w_rtype && (funct == c_FN_JR);
    assign w_ori     = (op == c_OP_ORI);
    assign w_lw      = (op == c_OP_LW);
    assign w_sw      = (op == c_OP_SW);
    assign w_beq     = (op == c_OP_BEQ);
    assign w_lui     = (op == c_OP_LUI);
    assign w_j       = (op == c_OP_J);
    assign w_jal     = (op == c_OP_JAL);
    assign w_is_mem  = w_lw | w_sw;
    assign w_is_alu  = w_addu | w_subu | w_ori | w_lui;
    assign w_is_jmp  = w_j | w_jal | w_jr;
    assign w_unknown = ~(w_is_mem | w_is_alu | w_beq | w_is_jmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = c_S_FETCH;
        w_retire = 1'b0;
        w_pc_wr  = 1'b0;
        w_ir_wr  = 1'b0;
        w_reg_wr = 1'b0;
        w_mem_wr = 1'b0;
        extop    = 2'b00;
        alu_src  = 1'b0;
        aluop    = 2'b00;
        reg_dst  = 2'b00;
        wd_sel   = 2'b00;
        npc_sel  = 2'b00;
        case (r_state)
            c_S_FETCH: begin
                w_ir_wr = 1'b1;
                w_pc_wr = 1'b1;
                w_next  = c_S_DECODE;
            end
            c_S_DECODE: begin
                if (w_is_mem) begin
                    w_next = c_S_MA;
                end else if (w_is_alu) begin
                    w_next = c_S_EXE;
                end else if (w_beq) begin
                    w_next = c_S_BR;
                end else if (w_is_jmp) begin
                    w_next = c_S_JMP;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    w_next = c_S_HALT;
`else
                    w_next   = c_S_FETCH;
                    w_retire = 1'b1;
`endif
                end
            end
            c_S_MA: begin
                alu_src = 1'b1;
                extop   = 2'b01;
                w_next  = w_lw ? c_S_MR : c_S_MW;
            end
            c_S_MR: begin
                w_next = c_S_WBM;
            end
            c_S_WBM: begin
                w_reg_wr = 1'b1;
                wd_sel   = 2'b01;
                w_retire = 1'b1;
            end
            c_S_MW: begin
                w_mem_wr = 1'b1;
                w_retire = 1'b1;
            end
            c_S_EXE: begin
                w_next = c_S_WBA;
                if (w_subu) begin
                    aluop = 2'b01;
                end else if (w_ori) begin
                    aluop   = 2'b10;
                    alu_src = 1'b1;
                end else if (w_lui) begin
                    // lui is an OR of the shifted immediate with $0
                    aluop   = 2'b10;
                    alu_src = 1'b1;
                    extop   = 2'b10;
                end
            end
            c_S_WBA: begin
                w_reg_wr = 1'b1;
                reg_dst  = w_rtype ? 2'b01 : 2'b00;
                w_retire = 1'b1;
            end
            c_S_BR: begin
                aluop    = 2'b01;
                extop    = 2'b01;
                w_pc_wr  = zero;
                npc_sel  = 2'b01;
                w_retire = 1'b1;
            end
            c_S_JMP: begin
                w_pc_wr  = 1'b1;
                npc_sel  = w_jr ? 2'b11 : 2'b10;
                w_retire = 1'b1;
                if (w_jal) begin
                    w_reg_wr = 1'b1;
                    reg_dst  = 2'b10;
                    wd_sel   = 2'b10;
                end
            end
`ifdef ILLEGAL_TRAP_EN
            c_S_HALT: begin
                w_next = c_S_HALT;
            end
`endif
            default: begin
                w_next = c_S_FETCH;
            end
        endcase
    end

    // Reset must suppress writes even though the reset state is fetch
    assign pc_wr  = w_pc_wr  & rst_n;
    assign ir_wr  = w_ir_wr  & rst_n;
    assign reg_wr = w_reg_wr & rst_n;
    assign mem_wr = w_mem_wr & rst_n;
    assign state  = r_state;

    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (r_state == c_S_DECODE && w_unknown) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle controller for the single-issue MIPS-subset datapath. It sequences every instruction through fetch, decode, execute, memory and writeback cycles.
- Drives the write enables, the mux selects and extop, which configures the immediate extender.
- Sits beside the datapath. Takes opcode/funct from the instruction register and the ALU zero flag. Also keeps a retired-instruction counter for the test bench and debug.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- RESET_STATE, 4'd0, state entered on reset (S_FETCH). Not intended to be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- op  input  6  IR[31:26].
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag, valid in S_BR.
- pc_wr  output  1  PC write enable.
- ir_wr  output  1  instruction register write enable.
- reg_wr  output  1  register file write enable.
- mem_wr  output  1  data memory write enable.
- extop  output  2  immediate extender mode: 00 zero-ext, 01 sign-ext, 10 imm16<<16.
- alu_src  output  1  0 = rt operand, 1 = imm32.
- aluop  output  2  00 add, 01 sub, 10 or.
- reg_dst  output  2  00 rt, 01 rd, 10 $31.
- wd_sel  output  2  00 ALU result, 01 memory data, 10 PC+4.
- npc_sel  output  2  00 PC+4, 01 branch target, 10 jump target, 11 rs.
- state  output  4  current state, for debug.
- retired  output  CNT_W  count of completed instructions.
- illegal  output  1  unknown opcode seen (sticky; only meaningful with the optional feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=S_FETCH, retired=0, illegal=0.
  - All write enables (pc_wr, ir_wr, reg_wr, mem_wr) forced to 0 while rst_n=0, regardless of state.
  - All other outputs are 0.
  - Reset mid-instruction abandons it with no partial write.
- Supported instructions:
  - R-type op=000000: addu funct=100001, subu funct=100011, jr funct=001000.
  - I-type and J-type: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- States: S_FETCH=0, S_DECODE=1, S_MA=2, S_MR=3, S_MW=4, S_WBM=5, S_EXE=6, S_WBA=7, S_BR=8, S_JMP=9, S_HALT=10.
- Outputs are Moore, decoded from state plus the latched op/funct. op/funct are stable from S_DECODE onward.
- Transitions and outputs per state:
  - S_FETCH: ir_wr=1, pc_wr=1, npc_sel=00 -> S_DECODE.
  - S_DECODE: no writes. Next state by instruction:
    - lw/sw -> S_MA.
    - addu/subu/ori/lui -> S_EXE.
    - beq -> S_BR.
    - j/jal/jr -> S_JMP.
    - Anything else -> see Optional Feature.
  - S_MA: alu_src=1, extop=01, aluop=00. lw -> S_MR, sw -> S_MW.
  - S_MR -> S_WBM.
  - S_WBM: reg_wr=1, reg_dst=00, wd_sel=01 -> S_FETCH, retired+1.
  - S_MW: mem_wr=1 -> S_FETCH, retired+1.
  - S_EXE: instruction-dependent settings:
    - addu: aluop=00, alu_src=0.
    - subu: aluop=01, alu_src=0.
    - ori: aluop=10, alu_src=1, extop=00.
    - lui: aluop=10, alu_src=1, extop=10 (OR with $0 operand).
    - Then -> S_WBA.
  - S_WBA: reg_wr=1, wd_sel=00; reg_dst=01 for R-type, 00 otherwise -> S_FETCH, retired+1.
  - S_BR: aluop=01, alu_src=0, extop=01; pc_wr=zero, npc_sel=01 -> S_FETCH, retired+1.
  - S_JMP: pc_wr=1; npc_sel=10 for j/jal, 11 for jr. jal additionally reg_wr=1, reg_dst=10, wd_sel=10 -> S_FETCH, retired+1.
- Latency in cycles: lw 5, sw 4, R-type/ori/lui 4, beq 3, jumps 3.
- retired wraps from 2^CNT_W-1 to 0 silently. It increments exactly once on the clock edge leaving each final state.
- Unused state encodings (11..15) -> S_FETCH next cycle, no writes.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: unknown op (or unknown funct with op=000000) in S_DECODE -> S_HALT.
  - illegal=1 (sticky), all write enables 0, retired frozen.
  - Remains in S_HALT until rst_n asserted.
- Not defined: unknown instruction treated as NOP. S_DECODE -> S_FETCH, retired+1, illegal tied 0, S_HALT unreachable.

Test Plan:
- rst_n low mid-S_MR of lw, then released -> state=0, retired=0, reg_wr never 1; next edge shows ir_wr=1, pc_wr=1.
- lw (op=100011) then sw (op=101011) -> state traces 0,1,2,3,5 and 0,1,2,4; extop=01 in S_MA; mem_wr=1 only in S_MW; retired=2.
- lui (op=001111) then ori (op=001101) -> extop=10 then 00 in S_EXE; reg_wr=1 with reg_dst=00 in S_WBA; retired=2.
- beq with zero=1, then beq with zero=0 -> pc_wr=1 then 0 in S_BR; npc_sel=01 both times; 3 cycles each.
- jal then jr (op=0, funct=001000) -> jal S_JMP: reg_wr=1, reg_dst=10, wd_sel=10, npc_sel=10; jr S_JMP: npc_sel=11, reg_wr=0.
- op=111111 -> with ILLEGAL_TRAP_EN: state=10, illegal=1, no further pc_wr, retired unchanged. Without: back to S_FETCH after 2 cycles, retired+1.
